// File: rtl/evr_sequence_recorder_if.sv
// Event-stream, CSR and status signals of the sequence recorder.
// The master side (decoder/CSR block) drives events and commands; the slave side is the recorder.
interface evr_sequence_recorder_if #(
    parameter int unsigned EVENTCODE_WIDTH = 8
) ();

    logic [EVENTCODE_WIDTH-1:0] evrEventTDATA;
    logic                       evrEventTVALID;
    logic                       evrSequenceStart;
    logic                       csrStrobe;
    logic [31:0]                csrData;
    logic [31:0]                status;
    logic [31:0]                sequenceReadback;
    logic                       recordBusy;

    modport master (
        output evrEventTDATA,
        output evrEventTVALID,
        output evrSequenceStart,
        output csrStrobe,
        output csrData,
        input  status,
        input  sequenceReadback,
        input  recordBusy
    );

    modport slave (
        input  evrEventTDATA,
        input  evrEventTVALID,
        input  evrSequenceStart,
        input  csrStrobe,
        input  csrData,
        output status,
        output sequenceReadback,
        output recordBusy
    );

endinterface

// File: rtl/evr_sequence_recorder.sv
// Event receiver sequence recorder: captures the decoded event stream as {gap, event} entries
// into a dual-port RAM, using the same gap encoding the generator's sequencer plays back.
// Captured entries are read back through a three-register CSR path.
module evr_sequence_recorder #(
    parameter int unsigned SEQUENCE_RAM_CAPACITY = 2048,
    parameter int unsigned EVENTCODE_WIDTH       = 8,
    parameter int unsigned SEQUENCE_GAP_WIDTH    = 28
) (
    input logic                 evrClk,
    input logic                 evrResetN,
    evr_sequence_recorder_if.slave bus
);

    localparam int unsigned A      = $clog2(SEQUENCE_RAM_CAPACITY);
    localparam int unsigned CountW = A + 1;
    localparam int unsigned EntryW = SEQUENCE_GAP_WIDTH + EVENTCODE_WIDTH;

    localparam logic [SEQUENCE_GAP_WIDTH-1:0] GapMax   = '1;
    localparam logic [EVENTCODE_WIDTH-1:0]    EndCode  = EVENTCODE_WIDTH'(8'h7F);
    localparam logic [CountW-1:0]             Capacity = CountW'(SEQUENCE_RAM_CAPACITY);

    typedef enum logic [1:0] {
        StIdle      = 2'd0,
        StArmed     = 2'd1,
        StRecording = 2'd2,
        StDone      = 2'd3
    } recorderState_t;

    recorderState_t stateQ, stateD;

    logic [CountW-1:0]             entryCountQ, entryCountD;
    logic [A-1:0]                  writeAddressQ, writeAddressD;
    logic [SEQUENCE_GAP_WIDTH-1:0] gapCounterQ, gapCounterD;
    logic [SEQUENCE_GAP_WIDTH-1:0] gapNext;
    logic                          endSeenQ, endSeenD;
    logic                          fullQ, fullD;
    logic                          gapSaturatedQ, gapSaturatedD;
    logic [7:0]                    startsIgnoredQ, startsIgnoredD;

    logic                          doRecord;
    logic [SEQUENCE_GAP_WIDTH-1:0] recordGap;
    logic                          ramWe;
    logic [EntryW-1:0]             ramWdata;

    logic [A-1:0]                  readAddressQ;
    logic                          readSelectQ;
    logic                          readSelectPipeQ;
    logic [EntryW-1:0]             ramReadQ;
    logic [31:0]                   sequenceReadbackQ;
    logic [31:0]                   statusQ;

    logic [EntryW-1:0]             ram [SEQUENCE_RAM_CAPACITY];

    // Command decode; abort always beats arm in the same word.
    logic [1:0] csrCommand;
    logic       setAddressCmd;
    logic       controlCmd;
    logic       abortCmd;
    logic       armCmd;
    logic       eventValid;

    assign csrCommand    = bus.csrData[31:30];
    assign setAddressCmd = bus.csrStrobe && (csrCommand == 2'd1);
    assign controlCmd    = bus.csrStrobe && (csrCommand == 2'd2);
    assign abortCmd      = controlCmd && bus.csrData[1];
    assign armCmd        = controlCmd && bus.csrData[0] && !bus.csrData[1];
    // A zero code on a valid beat is a null event and never recorded.
    assign eventValid    = bus.evrEventTVALID && (bus.evrEventTDATA != '0);
    assign gapNext       = gapCounterQ + 1'b1;

    // Capture state and counter registers.
    always_ff @(posedge evrClk or negedge evrResetN) begin
        if (!evrResetN) begin
            stateQ         <= StIdle;
            entryCountQ    <= '0;
            writeAddressQ  <= '0;
            gapCounterQ    <= '0;
            endSeenQ       <= 1'b0;
            fullQ          <= 1'b0;
            gapSaturatedQ  <= 1'b0;
            startsIgnoredQ <= '0;
        end else begin
            stateQ         <= stateD;
            entryCountQ    <= entryCountD;
            writeAddressQ  <= writeAddressD;
            gapCounterQ    <= gapCounterD;
            endSeenQ       <= endSeenD;
            fullQ          <= fullD;
            gapSaturatedQ  <= gapSaturatedD;
            startsIgnoredQ <= startsIgnoredD;
        end
    end

    // Next-state, recording decision and RAM write controls.
    always_comb begin
        stateD         = stateQ;
        entryCountD    = entryCountQ;
        writeAddressD  = writeAddressQ;
        gapCounterD    = gapCounterQ;
        endSeenD       = endSeenQ;
        fullD          = fullQ;
        gapSaturatedD  = gapSaturatedQ;
        startsIgnoredD = startsIgnoredQ;
        doRecord       = 1'b0;
        recordGap      = gapCounterQ;

        if (bus.evrSequenceStart && (stateQ != StArmed) && (startsIgnoredQ != 8'hFF)) begin
            startsIgnoredD = startsIgnoredQ + 8'd1;
        end

        if (abortCmd) begin
            stateD = StIdle;
        end else if (armCmd && ((stateQ == StIdle) || (stateQ == StDone))) begin
            stateD        = StArmed;
            entryCountD   = '0;
            writeAddressD = '0;
            gapCounterD   = '0;
            endSeenD      = 1'b0;
            fullD         = 1'b0;
            gapSaturatedD = 1'b0;
        end else begin
            unique case (stateQ)
                StArmed: begin
                    if (bus.evrSequenceStart) begin
                        stateD      = StRecording;
                        gapCounterD = '0;
                        // An event on the start cycle is the first entry, with gap 0.
                        if (eventValid) begin
                            doRecord  = 1'b1;
                            recordGap = '0;
                        end
                    end
                end
                StRecording: begin
                    if (eventValid) begin
                        doRecord = 1'b1;
                    end else if (gapCounterQ != GapMax) begin
                        gapCounterD = gapNext;
                        if (gapNext == GapMax) begin
                            gapSaturatedD = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end

        ramWe    = doRecord;
        ramWdata = {recordGap, bus.evrEventTDATA};

        if (doRecord) begin
            writeAddressD = writeAddressQ + 1'b1;
            entryCountD   = entryCountQ + 1'b1;
            gapCounterD   = '0;
            if (bus.evrEventTDATA == EndCode) begin
                endSeenD = 1'b1;
                stateD   = StDone;
            end else if (entryCountD == Capacity) begin
                fullD  = 1'b1;
                stateD = StDone;
            end
        end
    end

    // Readback address and select, loaded by the set-address command.
    always_ff @(posedge evrClk or negedge evrResetN) begin
        if (!evrResetN) begin
            readAddressQ <= '0;
            readSelectQ  <= 1'b0;
        end else if (setAddressCmd) begin
            readAddressQ <= bus.csrData[A-1:0];
            readSelectQ  <= bus.csrData[24];
        end
    end

    // Simple dual-port RAM; the registered read returns old data on a same-address write.
    always_ff @(posedge evrClk) begin
        if (ramWe) begin
            ram[writeAddressQ] <= ramWdata;
        end
        ramReadQ <= ram[readAddressQ];
    end

    // Output register of the readback path; select is delayed to line up with the RAM data.
    always_ff @(posedge evrClk or negedge evrResetN) begin
        if (!evrResetN) begin
            readSelectPipeQ   <= 1'b0;
            sequenceReadbackQ <= '0;
        end else begin
            readSelectPipeQ <= readSelectQ;
            if (readSelectPipeQ) begin
                sequenceReadbackQ <= 32'(ramReadQ[EVENTCODE_WIDTH-1:0]);
            end else begin
                sequenceReadbackQ <= 32'(ramReadQ[EntryW-1:EVENTCODE_WIDTH]);
            end
        end
    end

    // Registered status word, one cycle behind the capture registers.
    always_ff @(posedge evrClk or negedge evrResetN) begin
        if (!evrResetN) begin
            statusQ <= '0;
        end else begin
            statusQ <= {5'(A), gapSaturatedQ, fullQ, endSeenQ, startsIgnoredQ, stateQ, 2'b00,
                        12'(entryCountQ)};
        end
    end

    assign bus.status           = statusQ;
    assign bus.sequenceReadback = sequenceReadbackQ;
    assign bus.recordBusy       = (stateQ == StArmed) || (stateQ == StRecording);

endmodule

// File: tb/tb_evr_sequence_recorder.sv
// Bench for evr_sequence_recorder: a 16-entry, 8-bit-gap instance driven cycle by cycle.
// Expected entries are queued as events are driven and drained through CSR readback.
module tb_evr_sequence_recorder;

    localparam int unsigned Cap  = 16;
    localparam int unsigned EvW  = 8;
    localparam int unsigned GapW = 8;

    logic evrClk    = 1'b0;
    logic evrResetN = 1'b0;

    evr_sequence_recorder_if #(.EVENTCODE_WIDTH(EvW)) bus ();

    evr_sequence_recorder #(
        .SEQUENCE_RAM_CAPACITY(Cap),
        .EVENTCODE_WIDTH(EvW),
        .SEQUENCE_GAP_WIDTH(GapW)
    ) dut (
        .evrClk(evrClk),
        .evrResetN(evrResetN),
        .bus(bus)
    );

    always #5 evrClk = ~evrClk;

    int errors = 0;
    int checks = 0;
    int expStartsIgn = 0;
    logic [15:0] expQ[$];   // {gap, code}

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge evrClk);
        #1;
    endtask

    task automatic beat(input logic start, input logic valid, input logic [7:0] code);
        bus.evrSequenceStart = start;
        bus.evrEventTVALID   = valid;
        bus.evrEventTDATA    = code;
        tick();
        bus.evrSequenceStart = 1'b0;
        bus.evrEventTVALID   = 1'b0;
        bus.evrEventTDATA    = '0;
    endtask

    task automatic csrWrite(input logic [1:0] cmd, input logic [29:0] payload);
        bus.csrStrobe = 1'b1;
        bus.csrData   = {cmd, payload};
        tick();
        bus.csrStrobe = 1'b0;
        bus.csrData   = '0;
    endtask

    task automatic readEntry(input int idx, input logic sel, output logic [31:0] val);
        logic [29:0] p;
        p      = '0;
        p[3:0] = idx[3:0];
        p[24]  = sel;
        csrWrite(2'd1, p);
        repeat (3) tick();
        val = bus.sequenceReadback;
    endtask

    function automatic logic [31:0] expStatus(input logic [1:0] st, input int cnt,
                                              input logic endS, input logic full,
                                              input logic sat);
        return {5'd4, sat, full, endS, expStartsIgn[7:0], st, 2'b00, cnt[11:0]};
    endfunction

    task automatic test_reset();
        repeat (2) tick();
        checks++;
        if (bus.status !== 32'h0) begin
            errors++;
            $display("FAIL reset status: got %h want %h", bus.status, 32'h0);
        end
        checks++;
        if (bus.sequenceReadback !== 32'h0) begin
            errors++;
            $display("FAIL reset readback: got %h want %h", bus.sequenceReadback, 32'h0);
        end
        checks++;
        if (bus.recordBusy !== 1'b0) begin
            errors++;
            $display("FAIL reset busy: got %b want 0", bus.recordBusy);
        end
        evrResetN = 1'b1;
        tick();
        checks++;
        if (bus.status !== expStatus(2'd0, 0, 1'b0, 1'b0, 1'b0)) begin
            errors++;
            $display("FAIL idle status: got %h want %h", bus.status,
                     expStatus(2'd0, 0, 1'b0, 1'b0, 1'b0));
        end
    endtask

    task automatic test_basic();
        logic [15:0] e;
        logic [31:0] rb;
        int idx;
        csrWrite(2'd2, 30'h1);
        checks++;
        if (bus.recordBusy !== 1'b1) begin
            errors++;
            $display("FAIL basic armed busy: got %b want 1", bus.recordBusy);
        end
        beat(1'b1, 1'b0, 8'h00);                 // cycle 0
        beat(1'b0, 1'b1, 8'h10); expQ.push_back({8'd0, 8'h10});
        beat(1'b0, 1'b1, 8'h11); expQ.push_back({8'd0, 8'h11});
        repeat (4) beat(1'b0, 1'b0, 8'h00);      // cycles 3..6
        beat(1'b0, 1'b1, 8'h12); expQ.push_back({8'd4, 8'h12});
        beat(1'b0, 1'b1, 8'h7F); expQ.push_back({8'd0, 8'h7F});
        beat(1'b0, 1'b1, 8'h55);                 // arrives in DONE, dropped
        checks++;
        if (bus.recordBusy !== 1'b0) begin
            errors++;
            $display("FAIL basic done busy: got %b want 0", bus.recordBusy);
        end
        checks++;
        if (bus.status !== expStatus(2'd3, 4, 1'b1, 1'b0, 1'b0)) begin
            errors++;
            $display("FAIL basic status: got %h want %h", bus.status,
                     expStatus(2'd3, 4, 1'b1, 1'b0, 1'b0));
        end
        idx = 0;
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            readEntry(idx, 1'b0, rb);
            checks++;
            if (rb !== {24'h0, e[15:8]}) begin
                errors++;
                $display("FAIL basic gap[%0d]: got %h want %h", idx, rb, {24'h0, e[15:8]});
            end
            readEntry(idx, 1'b1, rb);
            checks++;
            if (rb !== {24'h0, e[7:0]}) begin
                errors++;
                $display("FAIL basic code[%0d]: got %h want %h", idx, rb, {24'h0, e[7:0]});
            end
            idx++;
        end
    endtask

    task automatic test_null_events();
        logic [15:0] e;
        logic [31:0] rb;
        int idx;
        csrWrite(2'd2, 30'h1);
        beat(1'b1, 1'b1, 8'h20); expQ.push_back({8'd0, 8'h20});
        repeat (2) beat(1'b0, 1'b0, 8'h00);      // cycles 1, 2
        repeat (2) beat(1'b0, 1'b1, 8'h00);      // null beats at 3, 4
        beat(1'b0, 1'b1, 8'h21); expQ.push_back({8'd4, 8'h21});
        csrWrite(2'd2, 30'h2);
        tick();
        checks++;
        if (bus.status !== expStatus(2'd0, 2, 1'b0, 1'b0, 1'b0)) begin
            errors++;
            $display("FAIL null status: got %h want %h", bus.status,
                     expStatus(2'd0, 2, 1'b0, 1'b0, 1'b0));
        end
        idx = 0;
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            readEntry(idx, 1'b0, rb);
            checks++;
            if (rb !== {24'h0, e[15:8]}) begin
                errors++;
                $display("FAIL null gap[%0d]: got %h want %h", idx, rb, {24'h0, e[15:8]});
            end
            readEntry(idx, 1'b1, rb);
            checks++;
            if (rb !== {24'h0, e[7:0]}) begin
                errors++;
                $display("FAIL null code[%0d]: got %h want %h", idx, rb, {24'h0, e[7:0]});
            end
            idx++;
        end
    endtask

    task automatic test_capacity();
        logic [15:0] e;
        logic [31:0] rb;
        logic [7:0] code;
        int idx;
        csrWrite(2'd2, 30'h1);
        beat(1'b1, 1'b0, 8'h00);
        for (int i = 1; i <= 20; i++) begin
            code = 8'h40 + 8'(i);
            beat(1'b0, 1'b1, code);
            if (i <= 16) expQ.push_back({8'd0, code});
        end
        tick();
        checks++;
        if (bus.status !== expStatus(2'd3, 16, 1'b0, 1'b1, 1'b0)) begin
            errors++;
            $display("FAIL capacity status: got %h want %h", bus.status,
                     expStatus(2'd3, 16, 1'b0, 1'b1, 1'b0));
        end
        idx = 0;
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            readEntry(idx, 1'b0, rb);
            checks++;
            if (rb !== {24'h0, e[15:8]}) begin
                errors++;
                $display("FAIL capacity gap[%0d]: got %h want %h", idx, rb, {24'h0, e[15:8]});
            end
            readEntry(idx, 1'b1, rb);
            checks++;
            if (rb !== {24'h0, e[7:0]}) begin
                errors++;
                $display("FAIL capacity code[%0d]: got %h want %h", idx, rb, {24'h0, e[7:0]});
            end
            idx++;
        end
    endtask

    task automatic test_gap_saturation();
        logic [15:0] e;
        logic [31:0] rb;
        int idx;
        csrWrite(2'd2, 30'h1);
        beat(1'b1, 1'b0, 8'h00);
        repeat (260) beat(1'b0, 1'b0, 8'h00);
        beat(1'b0, 1'b1, 8'h30); expQ.push_back({8'hFF, 8'h30});
        beat(1'b0, 1'b1, 8'h7F); expQ.push_back({8'h00, 8'h7F});
        tick();
        checks++;
        if (bus.status !== expStatus(2'd3, 2, 1'b1, 1'b0, 1'b1)) begin
            errors++;
            $display("FAIL gapsat status: got %h want %h", bus.status,
                     expStatus(2'd3, 2, 1'b1, 1'b0, 1'b1));
        end
        idx = 0;
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            readEntry(idx, 1'b0, rb);
            checks++;
            if (rb !== {24'h0, e[15:8]}) begin
                errors++;
                $display("FAIL gapsat gap[%0d]: got %h want %h", idx, rb, {24'h0, e[15:8]});
            end
            readEntry(idx, 1'b1, rb);
            checks++;
            if (rb !== {24'h0, e[7:0]}) begin
                errors++;
                $display("FAIL gapsat code[%0d]: got %h want %h", idx, rb, {24'h0, e[7:0]});
            end
            idx++;
        end
    endtask

    task automatic test_starts_and_abort();
        logic [15:0] e;
        logic [31:0] rb;
        int idx;
        // Arm from DONE clears count and all flags.
        csrWrite(2'd2, 30'h1);
        tick();
        checks++;
        if (bus.status !== expStatus(2'd1, 0, 1'b0, 1'b0, 1'b0)) begin
            errors++;
            $display("FAIL arm clear status: got %h want %h", bus.status,
                     expStatus(2'd1, 0, 1'b0, 1'b0, 1'b0));
        end
        beat(1'b1, 1'b0, 8'h00);
        beat(1'b1, 1'b0, 8'h00); expStartsIgn++;     // start while RECORDING
        beat(1'b0, 1'b1, 8'h61); expQ.push_back({8'd1, 8'h61});
        beat(1'b0, 1'b1, 8'h62); expQ.push_back({8'd0, 8'h62});
        beat(1'b0, 1'b1, 8'h63); expQ.push_back({8'd0, 8'h63});
        csrWrite(2'd2, 30'h2);                       // abort mid-capture
        beat(1'b1, 1'b0, 8'h00); expStartsIgn++;     // start while IDLE
        tick();
        checks++;
        if (bus.status !== expStatus(2'd0, 3, 1'b0, 1'b0, 1'b0)) begin
            errors++;
            $display("FAIL abort status: got %h want %h", bus.status,
                     expStatus(2'd0, 3, 1'b0, 1'b0, 1'b0));
        end
        idx = 0;
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            readEntry(idx, 1'b0, rb);
            checks++;
            if (rb !== {24'h0, e[15:8]}) begin
                errors++;
                $display("FAIL abort gap[%0d]: got %h want %h", idx, rb, {24'h0, e[15:8]});
            end
            readEntry(idx, 1'b1, rb);
            checks++;
            if (rb !== {24'h0, e[7:0]}) begin
                errors++;
                $display("FAIL abort code[%0d]: got %h want %h", idx, rb, {24'h0, e[7:0]});
            end
            idx++;
        end
        // Arm and abort together: abort wins, nothing is cleared.
        csrWrite(2'd2, 30'h3);
        tick();
        checks++;
        if (bus.status !== expStatus(2'd0, 3, 1'b0, 1'b0, 1'b0)) begin
            errors++;
            $display("FAIL arm+abort status: got %h want %h", bus.status,
                     expStatus(2'd0, 3, 1'b0, 1'b0, 1'b0));
        end
        // Start, event and abort in one cycle: nothing recorded.
        csrWrite(2'd2, 30'h1);
        bus.csrStrobe = 1'b1;
        bus.csrData   = {2'd2, 30'h2};
        beat(1'b1, 1'b1, 8'h66);
        bus.csrStrobe = 1'b0;
        bus.csrData   = '0;
        tick();
        checks++;
        if (bus.status !== expStatus(2'd0, 0, 1'b0, 1'b0, 1'b0)) begin
            errors++;
            $display("FAIL start+abort status: got %h want %h", bus.status,
                     expStatus(2'd0, 0, 1'b0, 1'b0, 1'b0));
        end
        // Arm while RECORDING is ignored.
        csrWrite(2'd2, 30'h1);
        beat(1'b1, 1'b0, 8'h00);
        beat(1'b0, 1'b1, 8'h71);
        csrWrite(2'd2, 30'h1);
        tick();
        checks++;
        if (bus.status !== expStatus(2'd2, 1, 1'b0, 1'b0, 1'b0)) begin
            errors++;
            $display("FAIL arm in rec status: got %h want %h", bus.status,
                     expStatus(2'd2, 1, 1'b0, 1'b0, 1'b0));
        end
    endtask

    task automatic test_reset_mid();
        checks++;
        if (bus.recordBusy !== 1'b1) begin
            errors++;
            $display("FAIL pre-reset busy: got %b want 1", bus.recordBusy);
        end
        @(posedge evrClk);
        #2;
        evrResetN = 1'b0;
        #1;
        checks++;
        if (bus.status !== 32'h0) begin
            errors++;
            $display("FAIL midreset status: got %h want %h", bus.status, 32'h0);
        end
        checks++;
        if (bus.sequenceReadback !== 32'h0) begin
            errors++;
            $display("FAIL midreset readback: got %h want %h", bus.sequenceReadback, 32'h0);
        end
        checks++;
        if (bus.recordBusy !== 1'b0) begin
            errors++;
            $display("FAIL midreset busy: got %b want 0", bus.recordBusy);
        end
        repeat (2) tick();
        evrResetN = 1'b1;
        tick();
    endtask

    initial begin
        bus.evrEventTDATA    = '0;
        bus.evrEventTVALID   = 1'b0;
        bus.evrSequenceStart = 1'b0;
        bus.csrStrobe        = 1'b0;
        bus.csrData          = '0;
        test_reset();
        test_basic();
        test_null_events();
        test_capacity();
        test_gap_saturation();
        test_starts_and_abort();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
